// File: rtl/line_mem_port_pkg.sv
// line_mem_port_pkg: shared state/op encodings and line geometry helper
package line_mem_port_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;
    typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;
    function automatic int line_size(input int line_addr_len);
        return 2 ** line_addr_len;
    endfunction
endpackage

// File: rtl/line_mem_port_if.sv
// line_mem_port_if: cache-side line request/grant bus
interface line_mem_port_if
    import line_mem_port_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 11
);
    localparam int LS = line_size(LINE_ADDR_LEN);
    logic rd_req, wr_req, gnt, busy;
    logic [MEM_ADDR_LEN-LINE_ADDR_LEN-1:0] addr;
    logic [32*LS-1:0] wr_line, rd_line;
    logic [31:0] rd_cnt, wr_cnt;
    modport master(output rd_req, wr_req, addr, wr_line, input rd_line, gnt, busy, rd_cnt, wr_cnt);
    modport slave(input rd_req, wr_req, addr, wr_line, output rd_line, gnt, busy, rd_cnt, wr_cnt);
endinterface

// File: rtl/line_mem_ram.sv
// line_mem_ram: single-port word RAM with registered read data
module line_mem_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);
    logic [31:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

// File: rtl/line_mem_port.sv
// line_mem_port: word-serial line refill/write-back port with fixed latency
module line_mem_port
    import line_mem_port_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 11,
    parameter int MEM_LATENCY   = 8
) (
    input logic clk,
    input logic rst,
    line_mem_port_if.slave bus
);
    localparam int LS = line_size(LINE_ADDR_LEN);
    localparam int AW = MEM_ADDR_LEN - LINE_ADDR_LEN;
    localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
    state_t state, state_nxt;
    op_t op;
    logic [AW-1:0] la;
    logic [32*LS-1:0] wl, shadow, line_nxt, rd_line;
    logic [LW-1:0] lat_cnt;
    logic [LINE_ADDR_LEN-1:0] word_cnt;
    logic [MEM_ADDR_LEN-1:0] ram_addr;
    logic [31:0] wdata, q, rd_cnt, wr_cnt;
    logic we, req, last;

    assign req = bus.rd_req | bus.wr_req;
    assign last = word_cnt == '1;
    assign bus.rd_line = rd_line;
    assign bus.rd_cnt = rd_cnt;
    assign bus.wr_cnt = wr_cnt;

    line_mem_ram #(.AW(MEM_ADDR_LEN)) ram (.clk(clk), .we(we), .addr(ram_addr), .wdata(wdata), .q(q));

    // reads run one word ahead so the final word is in q on the DONE-entry edge
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req && MEM_LATENCY == 0) state_nxt = XFER; else if (req) state_nxt = WAIT;
            WAIT: if (32'(lat_cnt) == MEM_LATENCY - 1) state_nxt = XFER;
            XFER: if (last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        we = rst && state == XFER && op == OP_WR;
        wdata = wl[32*word_cnt +: 32];
        ram_addr = state == XFER && op == OP_WR ? {la, word_cnt}
                 : state == XFER ? {la, word_cnt + 1'b1}
                 : state == WAIT ? {la, {LINE_ADDR_LEN{1'b0}}}
                 : {bus.addr, {LINE_ADDR_LEN{1'b0}}};
        line_nxt = shadow;
        line_nxt[32*word_cnt +: 32] = q;
        bus.gnt = state == DONE;
        bus.busy = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rd_line <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                la <= bus.addr;
                wl <= bus.wr_line;
                op <= op_t'(bus.wr_req);
                lat_cnt <= '0;
                word_cnt <= '0;
            end
            if (state == WAIT) lat_cnt <= lat_cnt + 1'b1;
            if (state == XFER) begin
                word_cnt <= word_cnt + 1'b1;
                shadow <= line_nxt;
            end
            if (state == XFER && last && op == OP_RD) begin
                rd_line <= line_nxt;
                rd_cnt <= rd_cnt + 1;
            end
            if (state == XFER && last && op == OP_WR) wr_cnt <= wr_cnt + 1;
        end
    end
endmodule
